// File: rtl/ddr_pkg.sv
// Shared types and default timing values for the DDR command arbiter.
package ddr_pkg;

    localparam int TRRD_DEFAULT = 4;
    localparam int TFAW_DEFAULT = 16;
    localparam int TRFC_DEFAULT = 32;

    localparam logic [2:0] RD_R  = 3'd0;
    localparam logic [2:0] RDA_R = 3'd1;
    localparam logic [2:0] WR_R  = 3'd2;
    localparam logic [2:0] WRA_R = 3'd3;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_type_e;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_REF_WAIT = 2'd2
    } arb_fsm_type;

    // Auto-precharge variants collapse onto the plain read/write command.
    function automatic cmd_type_e cas_cmd(input logic [2:0] code);
        return (code == WR_R || code == WRA_R) ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// Request/grant/command bundle between the sequencers and the arbiter.
interface ddr_cmd_arbiter_if;
    import ddr_pkg::*;

    // Handshake: a requester raises *_req and holds it until it observes its
    // one-cycle *_gnt pulse; the pulse coincides with cmd_valid/cmd_type.
    logic        ref_req;
    logic        pre_req;
    logic        cas_req;
    logic        act_req;
    logic [2:0]  cas_type;
    logic        banks_idle;
    logic        ref_gnt;
    logic        pre_gnt;
    logic        cas_gnt;
    logic        act_gnt;
    logic        cmd_valid;
    cmd_type_e   cmd_type;
    logic        arb_busy;
    arb_fsm_type fsm_state;

    modport master (
        output ref_req, pre_req, cas_req, act_req, cas_type, banks_idle,
        input  ref_gnt, pre_gnt, cas_gnt, act_gnt, cmd_valid, cmd_type,
        input  arb_busy, fsm_state
    );

    modport slave (
        input  ref_req, pre_req, cas_req, act_req, cas_type, banks_idle,
        output ref_gnt, pre_gnt, cas_gnt, act_gnt, cmd_valid, cmd_type,
        output arb_busy, fsm_state
    );

endinterface

// File: rtl/faw_window.sv
// Four-slot rolling tFAW tracker: act_ok is high while fewer than four ACTs
// fall inside the current window.
module faw_window
    import ddr_pkg::*;
#(
    parameter int tFAW = TFAW_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic slot_load,
    output logic act_ok
);

    localparam int W = $clog2(tFAW + 1);

    logic [W-1:0] slot_q [4];
    logic [W-1:0] slot_d [4];
    logic [2:0]   busy_cnt;
    logic         loaded;

    always_comb begin
        busy_cnt = '0;
        loaded   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = (slot_q[i] != '0) ? slot_q[i] - W'(1) : slot_q[i];
            if (slot_q[i] != '0) begin
                busy_cnt = busy_cnt + 3'd1;
            end else if (slot_load && !loaded) begin
                // First free slot captures the new ACT.
                slot_d[i] = W'(tFAW - 1);
                loaded    = 1'b1;
            end
        end
        act_ok = (busy_cnt < 3'd4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Fixed-priority DDR command arbiter (REF > PRE > CAS > ACT) with tRRD/tFAW
// ACT pacing and a tRFC blackout after each refresh.
module ddr_cmd_arbiter
    import ddr_pkg::*;
#(
    parameter int tRRD = TRRD_DEFAULT,
    parameter int tFAW = TFAW_DEFAULT,
    parameter int tRFC = TRFC_DEFAULT
) (
    input logic              CK_t,
    input logic              reset_n,
    ddr_cmd_arbiter_if.slave arb
);

    localparam int RRD_W = $clog2(tRRD + 1);
    localparam int RFC_W = $clog2(tRFC + 1);

    arb_fsm_type state_q, state_d;
    logic        ref_gnt_q, ref_gnt_d;
    logic        pre_gnt_q, pre_gnt_d;
    logic        cas_gnt_q, cas_gnt_d;
    logic        act_gnt_q, act_gnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_type_e   cmd_type_q, cmd_type_d;
    logic        arb_busy_q, arb_busy_d;
    logic [RRD_W-1:0] rrd_q, rrd_d;
    logic [RFC_W-1:0] rfc_q, rfc_d;

    logic act_ok;
    logic ref_elig, pre_elig, cas_elig, act_elig;

    faw_window #(.tFAW(tFAW)) u_faw (
        .clk      (CK_t),
        .rst_n    (reset_n),
        .slot_load(act_gnt_d),
        .act_ok   (act_ok)
    );

    always_comb begin
        state_d     = state_q;
        ref_gnt_d   = 1'b0;
        pre_gnt_d   = 1'b0;
        cas_gnt_d   = 1'b0;
        act_gnt_d   = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_type_d  = CMD_NOP;
        rrd_d       = (rrd_q != '0) ? rrd_q - RRD_W'(1) : rrd_q;
        rfc_d       = (rfc_q != '0) ? rfc_q - RFC_W'(1) : rfc_q;

        // A source just granted still holds req this cycle; mask it.
        ref_elig = arb.ref_req && arb.banks_idle && !ref_gnt_q;
        pre_elig = arb.pre_req && !pre_gnt_q;
        cas_elig = arb.cas_req && !cas_gnt_q;
        act_elig = arb.act_req && !act_gnt_q && (rrd_q == '0) && act_ok;

        unique case (state_q)
            ARB_REF_WAIT: begin
                if (rfc_q == '0) state_d = ARB_IDLE;
            end
            default: begin
                state_d     = ARB_ISSUE;
                cmd_valid_d = 1'b1;
                if (ref_elig) begin
                    ref_gnt_d  = 1'b1;
                    cmd_type_d = CMD_REF;
                    state_d    = ARB_REF_WAIT;
                    rfc_d      = RFC_W'(tRFC - 1);
                end else if (pre_elig) begin
                    pre_gnt_d  = 1'b1;
                    cmd_type_d = CMD_PRE;
                end else if (cas_elig) begin
                    cas_gnt_d  = 1'b1;
                    cmd_type_d = cas_cmd(arb.cas_type);
                end else if (act_elig) begin
                    act_gnt_d  = 1'b1;
                    cmd_type_d = CMD_ACT;
                    rrd_d      = RRD_W'(tRRD - 1);
                end else begin
                    state_d     = ARB_IDLE;
                    cmd_valid_d = 1'b0;
                end
            end
        endcase

        arb_busy_d = (state_d == ARB_REF_WAIT);
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            ref_gnt_q   <= 1'b0;
            pre_gnt_q   <= 1'b0;
            cas_gnt_q   <= 1'b0;
            act_gnt_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NOP;
            arb_busy_q  <= 1'b0;
            rrd_q       <= '0;
            rfc_q       <= '0;
        end else begin
            state_q     <= state_d;
            ref_gnt_q   <= ref_gnt_d;
            pre_gnt_q   <= pre_gnt_d;
            cas_gnt_q   <= cas_gnt_d;
            act_gnt_q   <= act_gnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            arb_busy_q  <= arb_busy_d;
            rrd_q       <= rrd_d;
            rfc_q       <= rfc_d;
        end
    end

    assign arb.ref_gnt   = ref_gnt_q;
    assign arb.pre_gnt   = pre_gnt_q;
    assign arb.cas_gnt   = cas_gnt_q;
    assign arb.act_gnt   = act_gnt_q;
    assign arb.cmd_valid = cmd_valid_q;
    assign arb.cmd_type  = cmd_type_q;
    assign arb.arb_busy  = arb_busy_q;
    assign arb.fsm_state = state_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: expected commands are queued with the
// clock stamp they must appear at and a negedge monitor checks them.
module tb_ddr_cmd_arbiter;
    import ddr_pkg::*;

    localparam int EW = 35;

    logic CK_t = 1'b0;
    logic reset_n;
    int   cyc = 0;

    ddr_cmd_arbiter_if bus();

    ddr_cmd_arbiter #(.tRRD(4), .tFAW(16), .tRFC(32)) dut (
        .CK_t   (CK_t),
        .reset_n(reset_n),
        .arb    (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            rst_q[$];
    int            busy_lo = 1;
    int            busy_hi = 0;
    logic          done = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic ref_seen = 1'b0, pre_seen = 1'b0, cas_seen = 1'b0, act_seen = 1'b0;
    logic act_hold = 1'b0;

    function automatic logic [EW-1:0] mk(input int stamp, input cmd_type_e t);
        return {stamp, t};
    endfunction

    function automatic logic [3:0] exp_gnt(input cmd_type_e t);
        case (t)
            CMD_REF:         return 4'b1000;
            CMD_PRE:         return 4'b0100;
            CMD_RD, CMD_WR:  return 4'b0010;
            CMD_ACT:         return 4'b0001;
            default:         return 4'b0000;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Requesters drop req one cycle after seeing their grant.
    task automatic step();
        @(negedge CK_t);
        if (ref_seen) begin bus.ref_req = 1'b0; ref_seen = 1'b0; end
        if (pre_seen) begin bus.pre_req = 1'b0; pre_seen = 1'b0; end
        if (cas_seen) begin bus.cas_req = 1'b0; cas_seen = 1'b0; end
        if (act_seen) begin bus.act_req = 1'b0; act_seen = 1'b0; end
        if (bus.ref_gnt === 1'b1) ref_seen = 1'b1;
        if (bus.pre_gnt === 1'b1) pre_seen = 1'b1;
        if (bus.cas_gnt === 1'b1) cas_seen = 1'b1;
        if (bus.act_gnt === 1'b1 && !act_hold) act_seen = 1'b1;
    endtask

    task automatic step_until(input int stamp);
        while (cyc < stamp) step();
    endtask

    initial begin
        int c;
        reset_n        = 1'b0;
        bus.ref_req    = 1'b0;
        bus.pre_req    = 1'b0;
        bus.cas_req    = 1'b0;
        bus.act_req    = 1'b0;
        bus.cas_type   = RD_R;
        bus.banks_idle = 1'b0;
        rst_q.push_back(1);
        rst_q.push_back(2);
        rst_q.push_back(3);
        step_until(3);
        reset_n = 1'b1;
        step_until(5);

        // ACT stream held high: tRRD spacing, fifth ACT at the tFAW edge
        c = cyc;
        bus.act_req = 1'b1;
        act_hold    = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(c + 1 + 4 * i, CMD_ACT));
        step_until(c + 17);
        bus.act_req = 1'b0;
        act_hold    = 1'b0;
        step_until(c + 40);

        // PRE + CAS(WR) + ACT together: priority order, one per cycle
        c = cyc;
        bus.pre_req  = 1'b1;
        bus.cas_req  = 1'b1;
        bus.cas_type = WR_R;
        bus.act_req  = 1'b1;
        exp_q.push_back(mk(c + 1, CMD_PRE));
        exp_q.push_back(mk(c + 2, CMD_WR));
        exp_q.push_back(mk(c + 3, CMD_ACT));
        step_until(c + 8);

        // CAS(RDA) + ACT together
        c = cyc;
        bus.cas_req  = 1'b1;
        bus.cas_type = RDA_R;
        bus.act_req  = 1'b1;
        exp_q.push_back(mk(c + 1, CMD_RD));
        exp_q.push_back(mk(c + 2, CMD_ACT));
        step_until(c + 6);

        // CAS(WRA) alone
        c = cyc;
        bus.cas_req  = 1'b1;
        bus.cas_type = WRA_R;
        exp_q.push_back(mk(c + 1, CMD_WR));
        step_until(c + 4);

        // REF with banks idle; CAS arriving during tRFC waits it out
        c = cyc;
        bus.banks_idle = 1'b1;
        bus.ref_req    = 1'b1;
        exp_q.push_back(mk(c + 1, CMD_REF));
        busy_lo = c + 1;
        busy_hi = c + 32;
        step_until(c + 5);
        bus.cas_req  = 1'b1;
        bus.cas_type = RD_R;
        exp_q.push_back(mk(c + 34, CMD_RD));
        step_until(c + 36);
        bus.banks_idle = 1'b0;

        // REF blocked by busy banks, ACT goes first; REF once banks idle
        c = cyc;
        bus.ref_req = 1'b1;
        bus.act_req = 1'b1;
        exp_q.push_back(mk(c + 1, CMD_ACT));
        step_until(c + 4);
        bus.banks_idle = 1'b1;
        exp_q.push_back(mk(c + 5, CMD_REF));
        busy_lo = c + 5;
        busy_hi = c + 36;
        step_until(c + 40);

        // Reset in the middle of tRFC, then an unstalled ACT
        c = cyc;
        bus.act_req = 1'b1;
        exp_q.push_back(mk(c + 1, CMD_ACT));
        step_until(c + 1);
        bus.ref_req = 1'b1;
        exp_q.push_back(mk(c + 2, CMD_REF));
        busy_lo = c + 2;
        busy_hi = c + 11;
        step_until(c + 11);
        reset_n     = 1'b0;
        bus.act_req = 1'b1;
        rst_q.push_back(c + 12);
        step_until(c + 12);
        reset_n = 1'b1;
        exp_q.push_back(mk(c + 13, CMD_ACT));
        step_until(c + 20);

        done = 1'b1;
        repeat (5) step();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CK_t) begin
        logic [EW-1:0] head;
        cmd_type_e     et;
        logic [3:0]    gv;
        logic          exp_busy;
        gv = {bus.ref_gnt, bus.pre_gnt, bus.cas_gnt, bus.act_gnt};
        if (cyc >= 1) begin
            if (rst_q.size() > 0 && rst_q[0] == cyc) begin
                void'(rst_q.pop_front());
                checks++;
                if (bus.cmd_valid !== 1'b0 || gv !== 4'b0000 || bus.cmd_type !== CMD_NOP ||
                    bus.arb_busy !== 1'b0 || bus.fsm_state !== ARB_IDLE) begin
                    errors++;
                    $display("FAIL reset @%0d: valid=%b gnt=%b type=%0d busy=%b state=%0d, required 0/0000/NOP/0/IDLE",
                             cyc, bus.cmd_valid, gv, bus.cmd_type, bus.arb_busy, bus.fsm_state);
                end
            end

            exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
            checks++;
            if (bus.arb_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy @%0d: got %b required %b", cyc, bus.arb_busy, exp_busy);
            end

            if (bus.cmd_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected cmd @%0d: got type %0d, required none", cyc, bus.cmd_type);
                end else begin
                    head = exp_q.pop_front();
                    et   = cmd_type_e'(head[2:0]);
                    if (int'(head[EW-1:3]) != cyc || bus.cmd_type !== et) begin
                        errors++;
                        $display("FAIL cmd: got type %0d @%0d, required type %0d @%0d",
                                 bus.cmd_type, cyc, et, int'(head[EW-1:3]));
                    end
                    checks++;
                    if (gv !== exp_gnt(et)) begin
                        errors++;
                        $display("FAIL gnt @%0d: got %b required %b", cyc, gv, exp_gnt(et));
                    end
                end
            end else begin
                checks++;
                if (bus.cmd_valid !== 1'b0 || gv !== 4'b0000 || bus.cmd_type !== CMD_NOP) begin
                    errors++;
                    $display("FAIL idle @%0d: valid=%b gnt=%b type=%0d, required 0/0000/NOP",
                             cyc, bus.cmd_valid, gv, bus.cmd_type);
                end
                if (exp_q.size() > 0 && int'(exp_q[0][EW-1:3]) <= cyc) begin
                    head = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing cmd: got none @%0d, required type %0d @%0d",
                             cyc, head[2:0], int'(head[EW-1:3]));
                end
            end

            if (done) begin
                checks++;
                if (exp_q.size() != 0 || rst_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got %0d cmds %0d resets pending, required 0 0",
                             exp_q.size(), rst_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule

// File: doc/ddr_cmd_arbiter.md
DDR_CMD_ARBITER -- requirements
Module: ddr_cmd_arbiter

Interface
REQ-001 SHALL have parameter tRRD, default 4, minimum cycles between consecutive ACT commands.
REQ-002 SHALL have parameter tFAW, default 16, window in cycles within which at most four ACT commands are issued.
REQ-003 SHALL have parameter tRFC, default 32, cycles after REF during which no command is issued.
REQ-004 CK_t  in  1  clock; the block has one clock; all logic updates on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 ref_req / pre_req / cas_req / act_req  in  1 each  command requests from the refresh, precharge, burst_cas and burst_act sequencers.
REQ-007 cas_type  in  3  request code (RD_R/RDA_R/WR_R/WRA_R) qualified by cas_req.
REQ-008 banks_idle  in  1  high when all banks are precharged.
REQ-009 ref_gnt / pre_gnt / cas_gnt / act_gnt  out  1 each  one-cycle grant pulses.
REQ-010 cmd_valid  out  1  a command is driven this cycle.
REQ-011 cmd_type  out  3  issued command, cmd_type_e.
REQ-012 arb_busy  out  1  high in ARB_REF_WAIT.

Function
REQ-013 SHALL issue at most one command per cycle; all outputs SHALL be registered.
REQ-014 Requests sampled at edge k SHALL produce a grant at edge k, visible in cycle k..k+1; gnt, cmd_valid and cmd_type SHALL assert together.
REQ-015 Each requester holds req until it sees its gnt; the arbiter SHALL NOT grant the same source in the cycle immediately after granting it.
REQ-016 Fixed priority: REF > PRE > CAS > ACT, among eligible requests only.
REQ-017 REF SHALL be eligible only when banks_idle=1.
REQ-018 ACT SHALL be eligible only when the tRRD counter is 0 and fewer than four tFAW window counters are nonzero.
REQ-019 On an ACT grant, the tRRD counter SHALL load tRRD-1, and a zero-valued tFAW slot SHALL load tFAW-1; nonzero counters decrement by 1 per cycle, saturating at 0.
REQ-020 cmd_type mapping: ACT->CMD_ACT; PRE->CMD_PRE; REF->CMD_REF; CAS with RD_R/RDA_R->CMD_RD; CAS with WR_R/WRA_R->CMD_WR; no grant->CMD_NOP with cmd_valid=0.
REQ-021 States: ARB_IDLE (no request eligible), ARB_ISSUE (grant made this cycle), ARB_REF_WAIT.
REQ-022 Transitions: IDLE/ISSUE -> ISSUE on any eligible request; IDLE/ISSUE -> IDLE when none is eligible; on a REF grant -> REF_WAIT.
REQ-023 REF_WAIT SHALL load a counter with tRFC-1, grant nothing, hold arb_busy=1, and return to IDLE when the counter reaches 0.
REQ-024 Pending requests SHALL be held, never dropped, while blocked; after REF_WAIT they are arbitrated by REQ-016.
REQ-025 Simultaneous REF and ACT with banks_idle=0: the ACT SHALL be granted if eligible, and REF waits.
REQ-026 Counters SHALL be wide enough for the parameter values, with no wrap-around.

Reset
REQ-027 While reset_n=0 at a rising edge: state=ARB_IDLE, all gnt=0, cmd_valid=0, cmd_type=CMD_NOP, arb_busy=0, and all tRRD/tFAW/tRFC counters=0.
REQ-028 Reset asserted mid-REF_WAIT or mid-window SHALL abort the wait and clear all counters at that edge.

Structure
REQ-029 cmd_type_e (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF), arb_fsm_type, and the default tRRD/tFAW/tRFC values SHALL be in ddr_pkg.pkg; RD_R/RDA_R/WR_R/WRA_R are reused from that package.
REQ-030 The four-slot tFAW tracker SHALL be one sub-module, faw_window, with outputs act_ok and slot-load input.

Verification
REQ-031 act_req held 1 and no other requests -> ACT grants at cycles 0, 4, 8, 12, then the next ACT at cycle 16 (tFAW limit), never closer than 4 cycles apart.
REQ-032 pre_req, cas_req (cas_type=WR_R) and act_req asserted in the same cycle -> PRE granted first, CMD_WR next cycle, CMD_ACT the cycle after; no double grants.
REQ-033 ref_req=1 with banks_idle=1 -> CMD_REF issued, arb_busy=1 for 32 cycles; a cas_req arriving meanwhile is granted on the first cycle after busy drops.
REQ-034 ref_req=1 with banks_idle=0 plus act_req -> ACT granted; REF is granted in the cycle after banks_idle rises.
REQ-035 reset_n driven low during cycle 10 of REF_WAIT -> at the next edge all outputs are at reset values, and a following act_req is granted with no tRRD/tFAW stall.
